// File: rtl/arp_arb_pkg.sv
// Shared definitions for the ARP request arbiter.
// Holds the transaction FSM state encoding.
package arp_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/arp_req_arbiter_rr_select.sv
// Combinational round-robin picker: req (PORTS) and last owner in,
// one-hot sel and sel_valid out; search starts at last+1.
module rr_select
  import arp_arb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int GW    = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [PORTS-1:0] sel,
  output logic             sel_valid
);

  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = GW'((int'(last) + i) % PORTS);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign sel_valid = found;

endmodule

// File: rtl/arp_req_arbiter.sv
// Transaction-level round-robin sharing of one ARP request/response
// channel among PORTS requesters (s_*), towards the arp block (m_*).
module arp_req_arbiter
  import arp_arb_pkg::*;
#(
  parameter int PORTS          = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           s_arp_request_valid,
  output logic [PORTS-1:0]           s_arp_request_ready,
  input  logic [PORTS*32-1:0]        s_arp_request_ip,
  output logic [PORTS-1:0]           s_arp_response_valid,
  input  logic [PORTS-1:0]           s_arp_response_ready,
  output logic [PORTS-1:0]           s_arp_response_error,
  output logic [PORTS*48-1:0]        s_arp_response_mac,
  output logic                       m_arp_request_valid,
  input  logic                       m_arp_request_ready,
  output logic [31:0]                m_arp_request_ip,
  input  logic                       m_arp_response_valid,
  output logic                       m_arp_response_ready,
  input  logic                       m_arp_response_error,
  input  logic [47:0]                m_arp_response_mac,
  output logic                       busy,
  output logic [$clog2(PORTS)-1:0]   grant,
  output logic                       stat_timeout,
  output logic                       stat_stray_drop
);

  localparam int GW   = $clog2(PORTS);
  localparam int TC_W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TC_W-1:0] TO_LAST =
    TC_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TC_W-1:0] TO_MAX = TC_W'(TIMEOUT_CYCLES);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [31:0]     ip_q, ip_d;
  logic            err_q, err_d;
  logic [47:0]     mac_q, mac_d;
  logic            stale_q, stale_d;
  logic [TC_W-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
  logic            stray_q, stray_d;

  logic [PORTS-1:0] sel;
  logic             sel_valid;
  logic [GW-1:0]    sel_idx;
  logic [31:0]      sel_ip;

  rr_select #(
    .PORTS(PORTS),
    .GW   (GW)
  ) u_rr (
    .req      (s_arp_request_valid),
    .last     (last_q),
    .sel      (sel),
    .sel_valid(sel_valid)
  );

  always_comb begin
    sel_idx = '0;
    sel_ip  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel[i]) begin
        sel_idx = GW'(i);
        sel_ip  = s_arp_request_ip[32*i +: 32];
      end
    end
  end

  // Handshake outputs are masked during reset so every valid/ready
  // reads 0 while rst is held.
  always_comb begin
    s_arp_request_ready  = '0;
    s_arp_response_valid = '0;
    s_arp_response_error = '0;
    m_arp_request_valid  = 1'b0;
    m_arp_response_ready = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        state_q == S_IDLE: begin
          s_arp_request_ready  = sel;
          m_arp_response_ready = 1'b1;
        end
        state_q == S_REQ:  m_arp_request_valid = 1'b1;
        state_q == S_WAIT: m_arp_response_ready = 1'b1;
        state_q == S_RESP: begin
          s_arp_response_valid[grant_q] = 1'b1;
          s_arp_response_error[grant_q] = err_q;
        end
        default: ;
      endcase
    end
  end

  assign s_arp_response_mac = {PORTS{mac_q}};
  assign m_arp_request_ip   = ip_q;
  assign busy               = (state_q != S_IDLE);
  assign grant              = grant_q;
  assign stat_timeout       = to_q;
  assign stat_stray_drop    = stray_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ip_d    = ip_q;
    err_d   = err_q;
    mac_d   = mac_q;
    stale_d = stale_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    stray_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Nobody owns the channel, so any response here is stray.
        if (m_arp_response_valid) begin
          stray_d = 1'b1;
          stale_d = 1'b0;
        end
        if (sel_valid) begin
          ip_d    = sel_ip;
          grant_d = sel_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (m_arp_request_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_arp_response_valid) begin
          err_d   = m_arp_response_error;
          mac_d   = m_arp_response_mac;
          state_d = S_RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          mac_d   = '0;
          to_d    = 1'b1;
          stale_d = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (s_arp_response_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= GW'(PORTS - 1);
      grant_q <= '0;
      ip_q    <= '0;
      err_q   <= 1'b0;
      mac_q   <= '0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ip_q    <= ip_d;
      err_q   <= err_d;
      mac_q   <= mac_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      stray_q <= stray_d;
    end
  end

endmodule

// File: tb/tb_arp_req_arbiter.sv
// Bench for arp_req_arbiter: directed scenarios followed by random
// traffic checked against a transaction-level reference model.
module tb_arp_req_arbiter;

  localparam int P = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    s_req_valid, s_req_ready;
  logic [P*32-1:0] s_req_ip;
  logic [P-1:0]    s_resp_valid, s_resp_ready, s_resp_error;
  logic [P*48-1:0] s_resp_mac;
  logic            m_req_valid, m_req_ready;
  logic [31:0]     m_req_ip;
  logic            m_resp_valid, m_resp_ready, m_resp_err;
  logic [47:0]     m_resp_mac;
  logic            busy;
  logic [1:0]      grant;
  logic            stat_to, stat_stray;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arp_req_arbiter #(.PORTS(P), .TIMEOUT_CYCLES(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_arp_request_valid (s_req_valid),
    .s_arp_request_ready (s_req_ready),
    .s_arp_request_ip    (s_req_ip),
    .s_arp_response_valid(s_resp_valid),
    .s_arp_response_ready(s_resp_ready),
    .s_arp_response_error(s_resp_error),
    .s_arp_response_mac  (s_resp_mac),
    .m_arp_request_valid (m_req_valid),
    .m_arp_request_ready (m_req_ready),
    .m_arp_request_ip    (m_req_ip),
    .m_arp_response_valid(m_resp_valid),
    .m_arp_response_ready(m_resp_ready),
    .m_arp_response_error(m_resp_err),
    .m_arp_response_mac  (m_resp_mac),
    .busy                (busy),
    .grant               (grant),
    .stat_timeout        (stat_to),
    .stat_stray_drop     (stat_stray)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P-1:0] oh(input int p);
    oh = '0;
    if (p >= 0) oh[p] = 1'b1;
  endfunction

  // Round-robin rule: first valid port after the previous owner.
  function automatic int rr_pick(input int lst, input logic [P-1:0] v);
    rr_pick = -1;
    for (int o = 1; o <= P; o++) begin
      int c;
      c = (lst + o) % P;
      if (rr_pick < 0 && v[c]) rr_pick = c;
    end
  endfunction

  task automatic req_hs(input int p, input logic [31:0] ip);
    bit ok;
    ok = 1'b0;
    s_req_valid[p] = 1'b1;
    s_req_ip[32*p +: 32] = ip;
    for (int k = 0; k < 30 && !ok; k++) begin
      #1;
      if (s_req_ready[p]) ok = 1'b1;
      tick();
    end
    s_req_valid[p] = 1'b0;
    chk("req_hs", 64'(ok), 64'd1);
  endtask

  task automatic arp_accept(input int hold, input logic [31:0] exp_ip);
    int k;
    k = 0;
    while (!m_req_valid && k < 30) begin
      tick();
      k++;
    end
    chk("m_req_valid", 64'(m_req_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("req_hold_valid", 64'(m_req_valid), 64'd1);
      chk("req_hold_ip", 64'(m_req_ip), 64'(exp_ip));
      tick();
    end
    chk("m_req_ip", 64'(m_req_ip), 64'(exp_ip));
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    #1;
    chk("req_once", 64'(m_req_valid), 64'd0);
  endtask

  task automatic arp_respond(input logic [47:0] mac, input logic err);
    int k;
    k = 0;
    while (!m_resp_ready && k < 30) begin
      tick();
      k++;
    end
    chk("m_resp_ready", 64'(m_resp_ready), 64'd1);
    m_resp_valid = 1'b1;
    m_resp_mac   = mac;
    m_resp_err   = err;
    tick();
    m_resp_valid = 1'b0;
  endtask

  task automatic port_resp(input int p, input int hold,
                           input logic [47:0] mac, input logic err);
    int k;
    k = 0;
    while (!s_resp_valid[p] && k < 30) begin
      tick();
      k++;
    end
    chk("resp_onehot", 64'(s_resp_valid), 64'(oh(p)));
    for (int i = 0; i < hold; i++) begin
      chk("resp_hold_valid", 64'(s_resp_valid), 64'(oh(p)));
      chk("resp_hold_mac", 64'(s_resp_mac[48*p +: 48]), 64'(mac));
      tick();
    end
    chk("resp_mac", 64'(s_resp_mac[48*p +: 48]), 64'(mac));
    chk("resp_err", 64'(s_resp_error[p]), 64'(err));
    s_resp_ready[p] = 1'b1;
    tick();
    s_resp_ready[p] = 1'b0;
    #1;
    chk("resp_once", 64'(s_resp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ipv [P];
    logic [31:0] rip [P];
    logic [31:0] own_ip;
    logic [47:0] exp_mac;
    logic        exp_err;
    int          e, k, phase, owner, mlast, lat, pick, drop_p;

    rst          = 1'b1;
    s_req_valid  = '0;
    s_req_ip     = '0;
    s_resp_ready = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_err   = 1'b0;
    m_resp_mac   = '0;
    repeat (3) tick();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("rst_m_resp_ready", 64'(m_resp_ready), 64'd0);
    chk("rst_s_resp_valid", 64'(s_resp_valid), 64'd0);
    chk("rst_stats", 64'({stat_to, stat_stray}), 64'd0);
    chk("rst_ip", 64'(m_req_ip), 64'd0);
    chk("rst_mac", 64'(s_resp_mac[47:0]), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_resp_ready", 64'(m_resp_ready), 64'd1);

    // Single requester with backpressure on both sides.
    req_hs(0, 32'h0A000005);
    chk("t1_grant", 64'(grant), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    arp_accept(5, 32'h0A000005);
    arp_respond(48'h020000000001, 1'b0);
    port_resp(0, 3, 48'h020000000001, 1'b0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Contention between ports 0 and 1; port 0 was last owner.
    for (int t = 0; t < 4; t++) begin
      e = (t % 2 == 0) ? 1 : 0;
      for (int p = 0; p < 2; p++) begin
        if (!s_req_valid[p]) begin
          ipv[p] = 32'h0A000100 + 32'(t * 16 + p);
          s_req_valid[p] = 1'b1;
          s_req_ip[32*p +: 32] = ipv[p];
        end
      end
      #1;
      chk("rr_grant", 64'(s_req_ready), 64'(oh(e)));
      tick();
      s_req_valid[e] = 1'b0;
      arp_accept(1, ipv[e]);
      arp_respond({16'h0200, ipv[e]}, 1'(t));
      port_resp(e, 0, {16'h0200, ipv[e]}, 1'(t));
    end
    s_req_valid = '0;

    // Timeout with a silent arp block, then a late stray response.
    req_hs(2, 32'h0A0000FE);
    arp_accept(0, 32'h0A0000FE);
    k = 0;
    while (!stat_to && k < 40) begin
      tick();
      k++;
    end
    chk("to_cycles", 64'(k), 64'd16);
    chk("to_resp_valid", 64'(s_resp_valid), 64'(oh(2)));
    chk("to_err", 64'(s_resp_error[2]), 64'd1);
    chk("to_mac", 64'(s_resp_mac[96 +: 48]), 64'd0);
    tick();
    chk("to_pulse", 64'(stat_to), 64'd0);
    port_resp(2, 0, 48'h0, 1'b1);
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'hDEADBEEF0001;
    #1;
    chk("stray_ready", 64'(m_resp_ready), 64'd1);
    tick();
    m_resp_valid = 1'b0;
    chk("stray_pulse", 64'(stat_stray), 64'd1);
    chk("stray_no_resp", 64'(s_resp_valid), 64'd0);
    tick();
    chk("stray_once", 64'(stat_stray), 64'd0);

    // Reset while waiting for the arp block.
    req_hs(1, 32'h0A000077);
    arp_accept(0, 32'h0A000077);
    rst = 1'b1;
    tick();
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_grant", 64'(grant), 64'd0);
    chk("mid_ip", 64'(m_req_ip), 64'd0);
    chk("mid_readys", 64'({m_resp_ready, m_req_valid}), 64'd0);
    rst = 1'b0;
    tick();
    m_resp_valid = 1'b1;
    tick();
    m_resp_valid = 1'b0;
    chk("mid_stray", 64'(stat_stray), 64'd1);
    s_req_valid = '1;
    #1;
    chk("mid_next_port0", 64'(s_req_ready), 64'(oh(0)));
    s_req_valid = '0;

    // Random traffic against the transaction-level model.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    phase  = 0;
    owner  = 0;
    mlast  = P - 1;
    lat    = 0;
    drop_p = -1;
    own_ip = '0;
    exp_mac = '0;
    exp_err = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < P; p++) begin
        if (!s_req_valid[p] && $urandom_range(0, 3) == 0) begin
          rip[p] = $urandom;
          s_req_valid[p] = 1'b1;
          s_req_ip[32*p +: 32] = rip[p];
        end
      end
      m_req_ready  = 1'($urandom_range(0, 1));
      s_resp_ready = P'($urandom);
      m_resp_valid = (phase == 2 && lat == 0);
      m_resp_mac   = {own_ip[15:0], own_ip};
      m_resp_err   = own_ip[0];
      if (phase == 2 && lat > 0) lat--;
      #1;
      pick = (phase == 0) ? rr_pick(mlast, s_req_valid) : -1;
      chk("rnd_req_ready", 64'(s_req_ready), 64'(oh(pick)));
      chk("rnd_m_req_valid", 64'(m_req_valid), 64'(phase == 1));
      chk("rnd_s_resp_valid", 64'(s_resp_valid),
          64'((phase == 3) ? oh(owner) : '0));
      if (phase == 1) begin
        chk("rnd_ip", 64'(m_req_ip), 64'(own_ip));
        chk("rnd_grant", 64'(grant), 64'(owner));
      end
      if (phase == 3) begin
        chk("rnd_mac", 64'(s_resp_mac[48*owner +: 48]), 64'(exp_mac));
        chk("rnd_err", 64'(s_resp_error[owner]), 64'(exp_err));
      end
      case (phase)
        0: if (pick >= 0) begin
          owner  = pick;
          own_ip = rip[pick];
          drop_p = pick;
          phase  = 1;
        end
        1: if (m_req_ready) begin
          lat   = $urandom_range(0, 6);
          phase = 2;
        end
        2: if (m_resp_valid) begin
          exp_mac = {own_ip[15:0], own_ip};
          exp_err = own_ip[0];
          phase   = 3;
        end
        default: if (s_resp_ready[owner]) begin
          mlast = owner;
          phase = 0;
        end
      endcase
      tick();
      if (drop_p >= 0) s_req_valid[drop_p] = 1'b0;
      drop_p = -1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
